// File: rtl/mod_mem_pkg.sv
// mod_mem_pkg: definitions shared by the memory stage and its neighbours.
//   state_t            memory-handshake FSM encoding (IDLE / WAIT)
//   FWD_SRC_*          select codes for the value forwarded from MEM to EX
//   ADDR_ALIGN_MASK    clears bit 0 so every access is halfword aligned
package mod_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Forwarding source select, shared with the forwarding unit.
    localparam logic FWD_SRC_ALU = 1'b0;
    localparam logic FWD_SRC_PC  = 1'b1;

    localparam logic [15:0] ADDR_ALIGN_MASK = 16'hFFFE;

endpackage

// File: rtl/mod_mem_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst           clock, synchronous active-high reset
//   en                 load new values (pipeline advancing)
//   regwrite_in, dstreg_in, data_in   next-stage values
//   wb_regwrite, wb_dstreg, wb_data   registered outputs
// When en is low a bubble is inserted: regwrite is killed while the
// destination and data hold their previous values.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        regwrite_in,
    input  logic [3:0]  dstreg_in,
    input  logic [15:0] data_in,
    output logic        wb_regwrite,
    output logic [3:0]  wb_dstreg,
    output logic [15:0] wb_data
);

    // MEM/WB register update with bubble insertion on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_regwrite <= 1'b0;
            wb_dstreg   <= 4'h0;
            wb_data     <= 16'h0000;
        end else if (en) begin
            wb_regwrite <= regwrite_in;
            wb_dstreg   <= dstreg_in;
            wb_data     <= data_in;
        end else begin
            wb_regwrite <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_mem.sv
// mod_mem: pipeline memory stage.
//   Drives the data-memory handshake (mem_req/mem_we/mem_addr/mem_wdata,
//   mem_rdata/mem_ready), stalls upstream while an access is outstanding,
//   aborts an access after TIMEOUT_CYCLES with a sticky mem_err, supplies
//   forward_DstData_MEM to EX and registers the MEM/WB outputs.
//   clk, rst (synchronous, active-high); control inputs memenable, memwrite,
//   memtoreg, pcread, regwrite_in, dstreg_in; datapath inputs aluout,
//   pc_plus2, store_data, forward_store, forward_DstData_WB.
module mod_mem
    import mod_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenable,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic        pcread,
    input  logic        regwrite_in,
    input  logic [3:0]  dstreg_in,
    input  logic [15:0] aluout,
    input  logic [15:0] pc_plus2,
    input  logic [15:0] store_data,
    input  logic        forward_store,
    input  logic [15:0] forward_DstData_WB,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [15:0] forward_DstData_MEM,
    output logic        wb_regwrite,
    output logic [3:0]  wb_dstreg,
    output logic [15:0] wb_data,
    output logic        mem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mem_err_r;

    logic               req_s;
    logic               timeout_s;
    logic               stall_s;
    logic [15:0]        load_data_s;
    logic [15:0]        fwd_s;
    logic [15:0]        wb_next_s;

    // Handshake, stall, timeout and write-back data selection.
    always_comb begin
        req_s       = 1'b0;
        fwd_s       = aluout;
        if (rst) begin
            req_s = 1'b0;
        end else if (state_r == ST_WAIT) begin
            req_s = 1'b1;
        end else begin
            req_s = memenable;
        end
        // A ready in the last allowed cycle wins over the abort.
        timeout_s   = (state_r == ST_WAIT) && (cnt_r == CNT_LAST) && !mem_ready;
        stall_s     = req_s && !mem_ready && !timeout_s;
        // An aborted load completes with zero data.
        load_data_s = timeout_s ? 16'h0000 : mem_rdata;
        case (pcread)
            FWD_SRC_PC:  fwd_s = pc_plus2;
            FWD_SRC_ALU: fwd_s = aluout;
            default:     fwd_s = aluout;
        endcase
        wb_next_s   = memtoreg ? load_data_s : fwd_s;
    end

    // Handshake FSM, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            mem_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (memenable && !mem_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (timeout_s) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= '0;
                        mem_err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .en          (!stall_s),
        .regwrite_in (regwrite_in),
        .dstreg_in   (dstreg_in),
        .data_in     (wb_next_s),
        .wb_regwrite (wb_regwrite),
        .wb_dstreg   (wb_dstreg),
        .wb_data     (wb_data)
    );

    assign mem_req             = req_s;
    assign mem_we              = req_s & memwrite;
    assign mem_addr            = aluout & ADDR_ALIGN_MASK;
    assign mem_wdata           = forward_store ? forward_DstData_WB : store_data;
    assign stall               = stall_s;
    assign forward_DstData_MEM = fwd_s;
    assign mem_err             = mem_err_r;

endmodule

// File: tb/tb_mod_mem.sv
module tb_mod_mem;
    import mod_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        memenable, memwrite, memtoreg, pcread, regwrite_in;
    logic [3:0]  dstreg_in;
    logic [15:0] aluout, pc_plus2, store_data, forward_DstData_WB;
    logic        forward_store;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, stall;
    logic [15:0] forward_DstData_MEM;
    logic        wb_regwrite;
    logic [3:0]  wb_dstreg;
    logic [15:0] wb_data;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    mod_mem u_dut (
        .clk(clk), .rst(rst),
        .memenable(memenable), .memwrite(memwrite), .memtoreg(memtoreg),
        .pcread(pcread), .regwrite_in(regwrite_in), .dstreg_in(dstreg_in),
        .aluout(aluout), .pc_plus2(pc_plus2), .store_data(store_data),
        .forward_store(forward_store), .forward_DstData_WB(forward_DstData_WB),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .forward_DstData_MEM(forward_DstData_MEM),
        .wb_regwrite(wb_regwrite), .wb_dstreg(wb_dstreg), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        memenable = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; pcread = 1'b0;
        regwrite_in = 1'b0; dstreg_in = 4'h0; aluout = 16'h0000;
        pc_plus2 = 16'h0000; store_data = 16'h0000; forward_store = 1'b0;
        forward_DstData_WB = 16'h0000; mem_rdata = 16'h0000; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++; if (wb_regwrite !== 1'b0) begin failures++; $display("FAIL reset_wb_regwrite got=%b exp=0", wb_regwrite); end
        checks++; if (wb_dstreg !== 4'h0) begin failures++; $display("FAIL reset_wb_dstreg got=%h exp=0", wb_dstreg); end
        checks++; if (wb_data !== 16'h0000) begin failures++; $display("FAIL reset_wb_data got=%h exp=0000", wb_data); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_req_stall got=%b%b exp=00", mem_req, stall); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        @(negedge clk);
        clear_inputs();
        aluout = 16'h1234; regwrite_in = 1'b1; dstreg_in = 4'h3;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL alu_req_stall got=%b%b exp=00", mem_req, stall); end
        checks++; if (forward_DstData_MEM !== 16'h1234) begin failures++; $display("FAIL alu_fwd got=%h exp=1234", forward_DstData_MEM); end
        @(negedge clk);
        checks++; if (wb_data !== 16'h1234) begin failures++; $display("FAIL alu_wb_data got=%h exp=1234", wb_data); end
        checks++; if (wb_dstreg !== 4'h3 || wb_regwrite !== 1'b1) begin failures++; $display("FAIL alu_wb_dst got=%h/%b exp=3/1", wb_dstreg, wb_regwrite); end
    endtask

    task automatic test_load_wait();
        clear_inputs();
        memenable = 1'b1; memtoreg = 1'b1; aluout = 16'h0011;
        regwrite_in = 1'b1; dstreg_in = 4'h5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL lw_wait_ctrl cyc=%0d got req/we/stall=%b%b%b exp=101", i, mem_req, mem_we, stall); end
            checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL lw_addr got=%h exp=0010", mem_addr); end
            @(negedge clk);
            checks++; if (wb_regwrite !== 1'b0) begin failures++; $display("FAIL lw_bubble cyc=%0d got=%b exp=0", i, wb_regwrite); end
        end
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL lw_ready got stall/req=%b%b exp=01", stall, mem_req); end
        @(negedge clk);
        checks++; if (wb_data !== 16'hBEEF || wb_regwrite !== 1'b1 || wb_dstreg !== 4'h5) begin failures++; $display("FAIL lw_wb got=%h/%b/%h exp=beef/1/5", wb_data, wb_regwrite, wb_dstreg); end
        clear_inputs();
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lw_back_idle got=%b exp=0", mem_req); end
    endtask

    task automatic test_store_zero_wait();
        @(negedge clk);
        clear_inputs();
        memenable = 1'b1; memwrite = 1'b1; forward_store = 1'b1;
        forward_DstData_WB = 16'h00AA; store_data = 16'h5555;
        aluout = 16'h0101; mem_ready = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL sw_we_stall got=%b%b exp=10", mem_we, stall); end
        checks++; if (mem_wdata !== 16'h00AA) begin failures++; $display("FAIL sw_wdata_fwd got=%h exp=00aa", mem_wdata); end
        checks++; if (mem_addr !== 16'h0100) begin failures++; $display("FAIL sw_addr got=%h exp=0100", mem_addr); end
        forward_store = 1'b0;
        #1;
        checks++; if (mem_wdata !== 16'h5555) begin failures++; $display("FAIL sw_wdata_reg got=%h exp=5555", mem_wdata); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (mem_req !== 1'b0 || u_dut.state_r !== ST_IDLE) begin failures++; $display("FAIL sw_idle got req/state=%b%b exp=00", mem_req, u_dut.state_r); end
    endtask

    task automatic test_ready_at_timeout();
        @(negedge clk);
        clear_inputs();
        memenable = 1'b1; memtoreg = 1'b1; aluout = 16'h0400;
        regwrite_in = 1'b1; dstreg_in = 4'h9;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL edge_stall cyc=%0d got=%b exp=1", i, stall); end
            @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = 16'hCAFE;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL edge_ready_stall got=%b exp=0", stall); end
        @(negedge clk);
        checks++; if (wb_data !== 16'hCAFE || mem_err !== 1'b0) begin failures++; $display("FAIL edge_complete got=%h/%b exp=cafe/0", wb_data, mem_err); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int stall_cnt;
        @(negedge clk);
        clear_inputs();
        memenable = 1'b1; memtoreg = 1'b1; aluout = 16'h2000;
        regwrite_in = 1'b1; dstreg_in = 4'h7; mem_rdata = 16'h1111;
        stall_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall !== 1'b1) break;
            stall_cnt++;
            @(negedge clk);
        end
        checks++; if (stall_cnt != 16) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=16", stall_cnt); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL to_err_early got=%b exp=0", mem_err); end
        @(negedge clk);
        checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", mem_err); end
        checks++; if (wb_data !== 16'h0000 || wb_regwrite !== 1'b1 || wb_dstreg !== 4'h7) begin failures++; $display("FAIL to_wb got=%h/%b/%h exp=0000/1/7", wb_data, wb_regwrite, wb_dstreg); end
        checks++; if (u_dut.state_r !== ST_IDLE) begin failures++; $display("FAIL to_state got=%b exp=0", u_dut.state_r); end
        clear_inputs();
        aluout = 16'h0777;
        @(negedge clk);
        checks++; if (mem_err !== 1'b1 || wb_data !== 16'h0777) begin failures++; $display("FAIL to_sticky got=%b/%h exp=1/0777", mem_err, wb_data); end
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        memenable = 1'b1; memtoreg = 1'b1; aluout = 16'h3000;
        regwrite_in = 1'b1; dstreg_in = 4'hA;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (u_dut.state_r !== ST_WAIT || mem_req !== 1'b1) begin failures++; $display("FAIL rw_in_wait got state/req=%b%b exp=11", u_dut.state_r, mem_req); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rw_req_forced got req/stall=%b%b exp=00", mem_req, stall); end
        @(negedge clk);
        memenable = 1'b0;
        #1;
        checks++; if (u_dut.state_r !== ST_IDLE || mem_err !== 1'b0) begin failures++; $display("FAIL rw_state_err got=%b/%b exp=0/0", u_dut.state_r, mem_err); end
        checks++; if (wb_regwrite !== 1'b0 || wb_dstreg !== 4'h0 || wb_data !== 16'h0000) begin failures++; $display("FAIL rw_wb got=%b/%h/%h exp=0/0/0000", wb_regwrite, wb_dstreg, wb_data); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_pcs();
        @(negedge clk);
        clear_inputs();
        pcread = 1'b1; pc_plus2 = 16'h0042; aluout = 16'h9999;
        regwrite_in = 1'b1; dstreg_in = 4'h2;
        #1;
        checks++; if (forward_DstData_MEM !== 16'h0042) begin failures++; $display("FAIL pcs_fwd got=%h exp=0042", forward_DstData_MEM); end
        @(negedge clk);
        checks++; if (wb_data !== 16'h0042 || wb_dstreg !== 4'h2) begin failures++; $display("FAIL pcs_wb got=%h/%h exp=0042/2", wb_data, wb_dstreg); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store_zero_wait();
        test_ready_at_timeout();
        test_timeout();
        test_reset_mid_wait();
        test_pcs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
